// File: rtl/f2c_dma_writer_if.sv
// f2c_dma_writer_if: Avalon BAS write port between the F2C DMA writer (master) and the PCIe slave.
interface f2c_dma_writer_if #(parameter int DATA_W = 512);
  logic                  waitrequest;
  logic [63:0]           address;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic [3:0]            burstcount;
  logic [DATA_W/8-1:0]   byteenable;
  modport master (input waitrequest, output address, write, writedata, burstcount, byteenable);
  modport slave (output waitrequest, input address, write, writedata, burstcount, byteenable);
endinterface

// File: rtl/f2c_dma_writer.sv
// f2c_dma_writer: writes packet flits as ring-bounded BAS bursts plus RX/TX-completion descriptors.
// Optional statistics counters are enabled by defining F2C_STATS_EN.
module f2c_dma_writer #(
  parameter int DATA_W = 512,
  parameter int RB_AWIDTH = 16,
  parameter int MAX_BURST = 8,
  parameter int QID_W = 16,
  parameter int TXC_MAX_CONSEC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    pkt_data,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic                 meta_valid,
  output logic                 meta_ready,
  input  logic [63:0]          meta_pkt_base,
  input  logic [RB_AWIDTH-1:0] meta_pkt_tail,
  input  logic [63:0]          meta_dsc_base,
  input  logic [RB_AWIDTH-1:0] meta_dsc_tail,
  input  logic [QID_W-1:0]     meta_qid,
  input  logic [15:0]          meta_size,
  input  logic                 meta_drop,
  input  logic                 meta_needs_dsc,
  input  logic                 meta_dsc_only,
  input  logic                 txc_valid,
  output logic                 txc_ready,
  input  logic [63:0]          txc_dsc_addr,
  input  logic [63:0]          txc_xfer_addr,
  input  logic [31:0]          txc_length,
  input  logic [RB_AWIDTH:0]   pkt_rb_size,
  f2c_dma_writer_if.master     bas,
  output logic [31:0]          wait_cycles
`ifdef F2C_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_bursts,
  output logic [31:0]          stat_dscs,
  output logic [31:0]          stat_drops
`endif
);
  localparam int BSH = $clog2(DATA_W / 8);
  typedef enum logic [1:0] {IDLE, BURST, DESC} state_t;
  state_t st, st_n;
  logic [RB_AWIDTH-1:0] tail_r, dsc_tail_r, tail_c, tail_n;
  logic [15:0] rem_r, rem_c, rem_n;
  logic [3:0] left_r, blen_r, left_c, left_n, len, cur_len;
  logic [63:0] base_r, dsc_base_r, base_c;
  logic [QID_W-1:0] qid_r;
  logic needs_r, sup_r, sup_c, needs_c, meta_sup;
  logic [7:0] txc_cnt;
  logic go, txc_go, start, meta_dsc, beat, dsc_go, new_burst;
  logic [31:0] room, lenw;
  logic [DATA_W-1:0] txc_d, dsc_d;
  always_comb begin
    go = !bas.waitrequest;
    meta_sup = meta_drop || meta_pkt_base == 64'd0 || meta_dsc_base == 64'd0;
    txc_go = st == IDLE && go && txc_valid && !(meta_valid && txc_cnt >= 8'(TXC_MAX_CONSEC));
    start = st == IDLE && go && !txc_go && meta_valid && !meta_dsc_only && pkt_valid;
    meta_dsc = go && meta_valid && meta_dsc_only && ((st == IDLE && !txc_go) || st == DESC);
    beat = start || (st == BURST && go && pkt_valid);
    dsc_go = st == DESC && go;
    tail_c = start ? meta_pkt_tail : tail_r;
    rem_c = start ? meta_size : rem_r;
    left_c = start ? 4'd0 : left_r;
    base_c = start ? meta_pkt_base : base_r;
    sup_c = start ? meta_sup : sup_r;
    needs_c = start ? meta_needs_dsc : needs_r;
    room = 32'(pkt_rb_size) - 32'(tail_c);
    lenw = 32'(MAX_BURST) < 32'(rem_c) ? 32'(MAX_BURST) : 32'(rem_c);
    lenw = room < lenw ? room : lenw;
    len = lenw[3:0];
    new_burst = left_c == 4'd0;
    cur_len = new_burst ? len : blen_r;
    left_n = (new_burst ? len : left_c) - 4'd1;
    tail_n = (tail_c + 1'b1) & RB_AWIDTH'(pkt_rb_size - 1'b1);
    rem_n = rem_c - 16'd1;
    st_n = meta_dsc ? DESC : beat ? (rem_n == 16'd0 ? (needs_c ? DESC : IDLE) : BURST) : dsc_go ? IDLE : st;
    txc_d = '0;
    txc_d[63:0] = {txc_xfer_addr[63:1], 1'b0};
    txc_d[95:64] = txc_length;
    dsc_d = '0;
    dsc_d[0] = 1'b1;
    dsc_d[32 +: RB_AWIDTH] = tail_r;
    dsc_d[64 +: QID_W] = qid_r;
  end
  assign pkt_ready = rst_n && beat;
  assign meta_ready = rst_n && (start || meta_dsc);
  assign txc_ready = rst_n && txc_go;
  assign bas.byteenable = '1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bas.write <= 1'b0;
      bas.address <= '0;
      bas.writedata <= '0;
      bas.burstcount <= '0;
      wait_cycles <= '0;
      tail_r <= '0;
      rem_r <= '0;
      left_r <= '0;
      blen_r <= '0;
      base_r <= '0;
      dsc_base_r <= '0;
      dsc_tail_r <= '0;
      qid_r <= '0;
      needs_r <= 1'b0;
      sup_r <= 1'b0;
      txc_cnt <= '0;
    end else begin
      wait_cycles <= wait_cycles + 32'(bas.waitrequest && wait_cycles != '1);
      if (go) begin
        bas.write <= 1'b0;
        if (txc_go) begin
          bas.write <= 1'b1;
          bas.address <= txc_dsc_addr;
          bas.writedata <= txc_d;
          bas.burstcount <= 4'd1;
        end else if (beat) begin
          bas.write <= !sup_c;
          bas.writedata <= pkt_data;
          bas.burstcount <= cur_len;
          if (new_burst) bas.address <= base_c + (64'(tail_c) << BSH);
        end else if (dsc_go) begin
          bas.write <= !sup_r;
          bas.address <= dsc_base_r + (64'(dsc_tail_r) << BSH);
          bas.writedata <= dsc_d;
          bas.burstcount <= 4'd1;
        end
      end
      if (txc_go) txc_cnt <= txc_cnt + 8'(txc_cnt < 8'(TXC_MAX_CONSEC));
      if (meta_ready) begin
        txc_cnt <= '0;
        base_r <= meta_pkt_base;
        dsc_base_r <= meta_dsc_base;
        dsc_tail_r <= meta_dsc_tail;
        qid_r <= meta_qid;
        needs_r <= meta_needs_dsc;
        sup_r <= meta_sup;
        tail_r <= meta_pkt_tail;
      end
      if (beat) begin
        tail_r <= tail_n;
        rem_r <= rem_n;
        left_r <= left_n;
        if (new_burst) blen_r <= len;
      end
    end
`ifdef F2C_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_pkts <= '0;
      stat_bursts <= '0;
      stat_dscs <= '0;
      stat_drops <= '0;
    end else begin
      stat_pkts <= stat_pkts + 32'(beat && rem_n == 16'd0 && !sup_c);
      stat_bursts <= stat_bursts + 32'(beat && new_burst && !sup_c);
      stat_dscs <= stat_dscs + 32'(dsc_go && !sup_r);
      stat_drops <= stat_drops + 32'(meta_ready && meta_sup);
    end
`endif
endmodule

// File: tb/tb_f2c_dma_writer.sv
// tb_f2c_dma_writer: directed bench for f2c_dma_writer (DATA_W=512, MAX_BURST=8, ring of 64 entries).
module tb_f2c_dma_writer;
  localparam int DW = 512;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [DW-1:0] pkt_data;
  logic pkt_valid = 1'b0, pkt_ready, meta_valid = 1'b0, meta_ready, txc_valid = 1'b0, txc_ready;
  logic [63:0] meta_pkt_base, meta_dsc_base, txc_dsc_addr, txc_xfer_addr;
  logic [15:0] meta_pkt_tail, meta_dsc_tail, meta_qid, meta_size;
  logic meta_drop, meta_needs_dsc, meta_dsc_only;
  logic [31:0] txc_length, wait_cycles;
  logic [16:0] pkt_rb_size = 17'd64;
`ifdef F2C_STATS_EN
  logic [31:0] stat_pkts, stat_bursts, stat_dscs, stat_drops;
`endif
  f2c_dma_writer_if #(.DATA_W(DW)) bas();
  f2c_dma_writer dut (
    .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_pkt_base(meta_pkt_base),
    .meta_pkt_tail(meta_pkt_tail), .meta_dsc_base(meta_dsc_base), .meta_dsc_tail(meta_dsc_tail),
    .meta_qid(meta_qid), .meta_size(meta_size), .meta_drop(meta_drop), .meta_needs_dsc(meta_needs_dsc),
    .meta_dsc_only(meta_dsc_only), .txc_valid(txc_valid), .txc_ready(txc_ready),
    .txc_dsc_addr(txc_dsc_addr), .txc_xfer_addr(txc_xfer_addr), .txc_length(txc_length),
    .pkt_rb_size(pkt_rb_size), .bas(bas.master), .wait_cycles(wait_cycles)
`ifdef F2C_STATS_EN
    , .stat_pkts(stat_pkts), .stat_bursts(stat_bursts), .stat_dscs(stat_dscs), .stat_drops(stat_drops)
`endif
  );
  typedef struct {logic [63:0] a; logic [DW-1:0] d; logic [3:0] bc;} wr_t;
  wr_t wq[$];
  always @(negedge clk)
    if (rst_n && bas.write && !bas.waitrequest) wq.push_back('{bas.address, bas.writedata, bas.burstcount});
  int checks = 0, errors = 0, consumed;
  logic stable_ok;
  logic [63:0] s_a;
  logic [DW-1:0] s_d;
  logic [3:0] s_bc;
  logic s_w;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] flit(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction
  function automatic logic [DW-1:0] dscd(input int tail, input logic [15:0] qid);
    logic [DW-1:0] d = '0;
    d[0] = 1'b1;
    d[63:32] = 32'(tail);
    d[79:64] = qid;
    return d;
  endfunction
  function automatic logic [DW-1:0] txcd(input int k);
    logic [DW-1:0] d = '0;
    d[63:0] = 64'h5000_0000 + 64'(k) * 64'h100;
    d[95:64] = 32'd100 + 32'(k);
    return d;
  endfunction
  function automatic wr_t wqa(input int i);
    wr_t w;
    w.a = '1;
    w.d = '1;
    w.bc = '1;
    if (i < wq.size()) w = wq[i];
    return w;
  endfunction
  function automatic int bad_data(input int lo, input int n);
    int b = 0;
    for (int i = 0; i < n; i++) if (wqa(lo + i).d !== flit(i)) b++;
    return b;
  endfunction
  task automatic set_txc(input int k);
    txc_dsc_addr = 64'h9000 + 64'(k) * 64;
    txc_xfer_addr = 64'h5000_0001 + 64'(k) * 64'h100;
    txc_length = 32'd100 + 32'(k);
  endtask
  task automatic run(input int size, input int tail, input logic [63:0] base, input logic [63:0] dbase,
                     input int dtail, input logic [15:0] qid, input logic drop, input logic needs,
                     input logic dso, input int ntxc, input int wr_at);
    int idx = 0, c = 0, tx = 0;
    logic md = 1'b0, pr, mr, tr;
    wq.delete();
    stable_ok = 1'b1;
    meta_pkt_tail = 16'(tail);
    meta_size = 16'(size);
    meta_pkt_base = base;
    meta_dsc_base = dbase;
    meta_dsc_tail = 16'(dtail);
    meta_qid = qid;
    meta_drop = drop;
    meta_needs_dsc = needs;
    meta_dsc_only = dso;
    meta_valid = 1'b1;
    pkt_data = flit(0);
    pkt_valid = size > 0;
    set_txc(0);
    txc_valid = ntxc > 0;
    while (!(md && idx == size && tx == ntxc) && c < 400) begin
      if (c == wr_at) begin
        bas.waitrequest = 1'b1;
        s_a = bas.address;
        s_d = bas.writedata;
        s_bc = bas.burstcount;
        s_w = bas.write;
      end
      if (c == wr_at + 10) bas.waitrequest = 1'b0;
      @(negedge clk);
      pr = pkt_ready;
      mr = meta_ready;
      tr = txc_ready;
      if (bas.waitrequest && {bas.address, bas.writedata, bas.burstcount, bas.write} !== {s_a, s_d, s_bc, s_w})
        stable_ok = 1'b0;
      @(posedge clk);
      #1;
      if (mr) begin
        md = 1'b1;
        meta_valid = 1'b0;
      end
      if (pr) begin
        idx++;
        pkt_data = flit(idx);
        pkt_valid = idx < size;
      end
      if (tr) begin
        tx++;
        set_txc(tx);
        txc_valid = tx < ntxc;
      end
      c++;
    end
    chk("run_bound", 1'(c < 400), 1'b1);
    bas.waitrequest = 1'b0;
    consumed = idx;
    repeat (6) @(posedge clk);
    #1;
  endtask
  initial begin
    int wc0;
    bas.waitrequest = 1'b0;
    meta_valid = 1'b1;
    meta_dsc_only = 1'b0;
    pkt_valid = 1'b1;
    txc_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_meta_ready", meta_ready, 1'b0);
    chk("rst_pkt_ready", pkt_ready, 1'b0);
    chk("rst_txc_ready", txc_ready, 1'b0);
    chk("rst_write", bas.write, 1'b0);
    chk("rst_address", bas.address, 64'd0);
    chk("rst_burstcount", bas.burstcount, 4'd0);
    chk("rst_writedata", bas.writedata, '0);
    chk("rst_wait_cycles", wait_cycles, 32'd0);
    chk("byteenable", bas.byteenable, {64{1'b1}});
    meta_valid = 1'b0;
    pkt_valid = 1'b0;
    txc_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(1, 5, 64'h1000, 64'h8000, 3, 16'h1234, 1'b0, 1'b1, 1'b0, 0, -1);
    chk("t1_count", 32'(wq.size()), 32'd2);
    chk("t1_addr", wqa(0).a, 64'h1140);
    chk("t1_bc", wqa(0).bc, 4'd1);
    chk("t1_data", wqa(0).d, flit(0));
    chk("t1_dsc_addr", wqa(1).a, 64'h80C0);
    chk("t1_dsc_data", wqa(1).d, dscd(6, 16'h1234));
    run(20, 0, 64'h10000, 64'h8000, 4, 16'h7, 1'b0, 1'b1, 1'b0, 0, -1);
    chk("t2_count", 32'(wq.size()), 32'd21);
    chk("t2_b0_addr", wqa(0).a, 64'h10000);
    chk("t2_b0_bc", wqa(7).bc, 4'd8);
    chk("t2_b1_addr", wqa(8).a, 64'h10200);
    chk("t2_b1_bc", wqa(8).bc, 4'd8);
    chk("t2_b2_addr", wqa(16).a, 64'h10400);
    chk("t2_b2_bc", wqa(19).bc, 4'd4);
    chk("t2_flits", 32'(bad_data(0, 20)), 32'd0);
    chk("t2_dsc_addr", wqa(20).a, 64'h8100);
    chk("t2_dsc_data", wqa(20).d, dscd(20, 16'h7));
    run(6, 62, 64'h20000, 64'h8000, 5, 16'h9, 1'b0, 1'b1, 1'b0, 0, -1);
    chk("t3_count", 32'(wq.size()), 32'd7);
    chk("t3_b0_addr", wqa(0).a, 64'h20F80);
    chk("t3_b0_bc", wqa(1).bc, 4'd2);
    chk("t3_b1_addr", wqa(2).a, 64'h20000);
    chk("t3_b1_bc", wqa(2).bc, 4'd4);
    chk("t3_flits", 32'(bad_data(0, 6)), 32'd0);
    chk("t3_dsc_data", wqa(6).d, dscd(4, 16'h9));
    run(2, 10, 64'h30000, 64'h8000, 0, 16'h1, 1'b0, 1'b0, 1'b0, 6, -1);
    chk("t4_count", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk("t4_txc_addr", wqa(i).a, 64'h9000 + 64'(i) * 64);
      chk("t4_txc_data", wqa(i).d, txcd(i));
    end
    chk("t4_pkt_addr", wqa(4).a, 64'h30280);
    chk("t4_pkt_bc", wqa(4).bc, 4'd2);
    chk("t4_flits", 32'(bad_data(4, 2)), 32'd0);
    chk("t4_txc4_addr", wqa(6).a, 64'h9100);
    chk("t4_txc4_data", wqa(6).d, txcd(4));
    chk("t4_txc5_data", wqa(7).d, txcd(5));
    chk("t4_txc5_bc", wqa(7).bc, 4'd1);
    wc0 = wait_cycles;
    run(12, 0, 64'h40000, 64'h8000, 0, 16'h1, 1'b0, 1'b0, 1'b0, 0, 3);
    chk("t5_stable", stable_ok, 1'b1);
    chk("t5_count", 32'(wq.size()), 32'd12);
    chk("t5_flits", 32'(bad_data(0, 12)), 32'd0);
    chk("t5_b1_addr", wqa(8).a, 64'h40200);
    chk("t5_b1_bc", wqa(8).bc, 4'd4);
    chk("t5_wait_cycles", wait_cycles, 32'(wc0 + 10));
    run(3, 20, 64'h50000, 64'h8000, 2, 16'h3, 1'b1, 1'b1, 1'b0, 0, -1);
    chk("t6_consumed", 32'(consumed), 32'd3);
    chk("t6_writes", 32'(wq.size()), 32'd0);
`ifdef F2C_STATS_EN
    chk("t6_stat_drops", stat_drops, 32'd1);
`endif
    run(0, 7, 64'h60000, 64'h8000, 9, 16'h55, 1'b0, 1'b1, 1'b1, 0, -1);
    chk("t7_count", 32'(wq.size()), 32'd1);
    chk("t7_addr", wqa(0).a, 64'h8240);
    chk("t7_data", wqa(0).d, dscd(7, 16'h55));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/f2c_dma_writer.md
Name: f2c_dma_writer

Overview:
- Parametrised successor of the FPGA-to-CPU DMA writer.
- Consumes a packet flit stream plus per-packet metadata, and writes packet data into the host packet ring as split Avalon bursts.
- Writes one RX descriptor per packet into the descriptor ring and interleaves TX-completion descriptors under a bounded-priority arbiter.
- Sits between the F2C packet/metadata FIFOs and the PCIe BAS write port.

Parameters:
- DATA_W, 512, flit/BAS data width in bits; power of two, at least 128.
- RB_AWIDTH, 16, ring index width; ring sizes go up to 2^RB_AWIDTH entries.
- MAX_BURST, 8, maximum flits per burst; 1..15.
- QID_W, 16, queue id width.
- TXC_MAX_CONSEC, 4, maximum back-to-back TX completions while packet metadata is pending.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pkt_data  in  DATA_W  packet flit
- pkt_valid  in  1  flit valid
- pkt_ready  out  1  flit accept
- meta_valid  in  1  metadata valid
- meta_ready  out  1  metadata accept
- meta_pkt_base  in  64  packet ring base; 0 = queue not configured
- meta_pkt_tail  in  RB_AWIDTH  packet ring tail
- meta_dsc_base  in  64  descriptor ring base; 0 = not configured
- meta_dsc_tail  in  RB_AWIDTH  descriptor ring tail
- meta_qid  in  QID_W  queue id
- meta_size  in  16  packet length in flits; at least 1 unless dsc_only
- meta_drop  in  1  suppress writes for this packet
- meta_needs_dsc  in  1  emit descriptor after data
- meta_dsc_only  in  1  descriptor only, no flits
- txc_valid  in  1  TX completion valid
- txc_ready  out  1  TX completion accept
- txc_dsc_addr  in  64  completion descriptor address
- txc_xfer_addr  in  64  completed transfer address
- txc_length  in  32  completed length
- pkt_rb_size  in  RB_AWIDTH+1  packet ring entries, power of two
- bas_waitrequest  in  1  slave stall
- bas_address  out  64
- bas_write  out  1
- bas_writedata  out  DATA_W
- bas_burstcount  out  4
- bas_byteenable  out  DATA_W/8  always all ones
- wait_cycles  out  32  cycles with bas_waitrequest high; saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - bas_write, bas_address, bas_writedata and bas_burstcount go to 0; wait_cycles goes to 0; state goes to IDLE.
  - pkt_ready, meta_ready and txc_ready are 0.
  - Asserting reset mid-burst abandons the burst; no recovery is attempted.
- Output stage:
  - One register stage. A beat issued in cycle N appears on bas_* in cycle N+1.
  - While bas_waitrequest is high, every bas_* output holds and no input is accepted.
  - bas_write drops once the beat is taken and no new beat is issued.
- State IDLE (all conditions below require bas_waitrequest low):
  - txc_valid is served first: single write, burstcount=1, address=txc_dsc_addr. Data: [63:0]=txc_xfer_addr with bit0=0 (signal=0), [95:64]=txc_length, all other bits 0.
  - Completion priority is bounded: a consecutive-completion counter increments per completion and clears on any metadata accept. When it reaches TXC_MAX_CONSEC and meta_valid is high, metadata wins that cycle.
  - meta_dsc_only: accept the metadata and go to DESC.
  - Otherwise, with meta_valid and pkt_valid both high: latch the metadata, take the first flit in the same cycle, and start a burst.
- Burst length: len = min(MAX_BURST, remaining, pkt_rb_size - tail).
  - Address = pkt_base + (DATA_W/8)*tail, driven on the first beat only.
  - Each beat carries burstcount=len, matching how the BAS slave latches bursts.
  - Per beat: tail <= (tail+1) & (pkt_rb_size-1); remaining decrements.
  - A burst never crosses the ring end. After the ring end, the next burst starts at tail 0.
- State BURST: beats advance only when pkt_valid is high and bas_waitrequest is low; pkt_ready is asserted exactly then.
  - After the last beat of a burst: if remaining > 0, start the next burst (no idle cycle). Otherwise go to DESC if needs_dsc, else IDLE.
- State DESC: single write, address = dsc_base + (DATA_W/8)*dsc_tail. Data: bit0=1, [63:32]=final packet tail (zero-extended), [63+QID_W:64]=qid, all other bits 0.
  - If the next metadata is dsc_only and valid, accept it in the same cycle and stay in DESC.
- meta_drop, pkt_base==0 or dsc_base==0: the flits are still consumed at the same rate, but bas_write stays 0 for those beats and for the descriptor.
- Simultaneous events:
  - txc_valid with meta_valid: completion wins unless the bound is reached.
  - txc_valid mid-packet: waits until IDLE.
- Arithmetic: address math is 64-bit modulo 2^64. wait_cycles saturates at 2^32-1.

Optional Feature:
- F2C_STATS_EN.
- Defined: adds outputs stat_pkts, stat_bursts, stat_dscs and stat_drops (32-bit each, wrapping). They count, respectively, last-beat packets, bursts issued, RX descriptors written, and dropped or unconfigured packets. All reset to 0.
- Undefined: these ports and their counters do not exist.

Test Plan:
- Single 1-flit packet, tail=5, base=0x1000, needs_dsc=1, DATA_W=512:
  - one write, address 0x1140, burstcount=1;
  - then a descriptor with tail=6 at dsc_base+64*dsc_tail.
- 20-flit packet, MAX_BURST=8, tail=0, ring 64: bursts of 8, 8 and 4 flits at tails 0, 8 and 16; final descriptor tail=20.
- 6-flit packet, tail=62, ring 64: bursts of 2 flits (tail 62) then 4 flits (address base+0); final tail=4.
- 6 TX completions pending plus valid metadata, TXC_MAX_CONSEC=4: 4 completions are written, then the packet, then the remaining 2.
- bas_waitrequest held high for 10 cycles mid-burst: outputs stable throughout, no flit loss, wait_cycles=10.
- meta_drop=1 on a 3-flit packet: 3 flits consumed, zero bas_write pulses; stat_drops=1 when F2C_STATS_EN is defined.
